riscv_mem_arbiter: RTL and testbench

- Shares one single-port memory between the riscv_simple instruction-fetch path and its load/store path.
- Three-state FSM; one outstanding transaction at a time.
- Data side has priority; a starvation counter guarantees fetch forward progress.
- Sits between the core (fetch and data requesters) and the unified memory model.

---
 rtl/riscv_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_arbiter.sv
// Arbiter that shares one single-port memory between the fetch and load/store paths.
// Optional statistics counters are enabled by defining RISCV_ARB_STATS_EN.
module riscv_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3,
  parameter int CNT_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
`ifdef RISCV_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_if_cnt,
  output logic [CNT_W-1:0] stat_d_cnt,
  output logic [CNT_W-1:0] stat_stall_cnt
`endif
);

  localparam int         BW         = DW / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_D      = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic [3:0]      starve_q, starve_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BW-1:0]   mem_be_q, mem_be_d;
  logic            if_gnt_q, if_gnt_d;
  logic            d_gnt_q, d_gnt_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic [DW-1:0]   if_rdata_q, if_rdata_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            busy_q, busy_d;
  logic            pick_if;

  // Next-state, arbitration and response capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    // Data wins unless the fetch side has already lost STARVE_MAX times in a row
    pick_if     = if_req && (!d_req || (starve_q == STARVE_LIM));

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          state_d   = ST_ISSUE;
          mem_req_d = 1'b1;
          if (pick_if) begin
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = {DW{1'b0}};
            mem_be_d    = {BW{1'b1}};
            if_gnt_d    = 1'b1;
            starve_d    = 4'd0;
          end else begin
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
            d_gnt_d     = 1'b1;
            if (if_req && (starve_q != STARVE_LIM)) begin
              starve_d = starve_q + 4'd1;
            end else begin
              starve_d = starve_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          state_d   = ST_WAIT;
          mem_req_d = 1'b0;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      ST_WAIT: begin
        mem_req_d = 1'b0;
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = d_rdata_q;
            end
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      starve_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      mem_be_q    <= {BW{1'b0}};
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= {DW{1'b0}};
      d_rdata_q   <= {DW{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_gnt_q    <= if_gnt_d;
      d_gnt_q     <= d_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign busy      = busy_q;

`ifdef RISCV_ARB_STATS_EN
  logic [CNT_W-1:0] stat_if_q, stat_if_d;
  logic [CNT_W-1:0] stat_d_q, stat_d_d;
  logic [CNT_W-1:0] stat_stall_q, stat_stall_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Counters are driven from the registered grant pulses so they match what the core sees
  always_comb begin
    stat_if_d    = stat_if_q;
    stat_d_d     = stat_d_q;
    stat_stall_d = stat_stall_q;
    if (if_gnt_q) begin
      stat_if_d = sat_inc(stat_if_q);
    end else begin
      stat_if_d = stat_if_q;
    end
    if (d_gnt_q) begin
      stat_d_d = sat_inc(stat_d_q);
    end else begin
      stat_d_d = stat_d_q;
    end
    if (if_req && !if_gnt_q && !d_gnt_q) begin
      stat_stall_d = sat_inc(stat_stall_q);
    end else begin
      stat_stall_d = stat_stall_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_if_q    <= {CNT_W{1'b0}};
      stat_d_q     <= {CNT_W{1'b0}};
      stat_stall_q <= {CNT_W{1'b0}};
    end else begin
      stat_if_q    <= stat_if_d;
      stat_d_q     <= stat_d_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_if_cnt    = stat_if_q;
  assign stat_d_cnt     = stat_d_q;
  assign stat_stall_cnt = stat_stall_q;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: scoreboard of expected responses plus a
// small memory model answering with ready one cycle late and rvalid one cycle after.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;
  logic [3:0]  d_be = 4'h0;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
`ifdef RISCV_ARB_STATS_EN
  logic [15:0] stat_if_cnt, stat_d_cnt, stat_stall_cnt;
`endif

  riscv_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
`ifdef RISCV_ARB_STATS_EN
    , .stat_if_cnt(stat_if_cnt), .stat_d_cnt(stat_d_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] last_d = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [7:0] i);
    return {8'hA0, i, ~i, i};
  endfunction

  // Memory model: auto mode, or manual drive from the stimulus block
  logic        mem_manual = 1'b0;
  logic        man_ready = 1'b0, man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        mdl_ready = 1'b0, mdl_rvalid = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;
  logic [31:0] acc_addr = 32'h0;
  logic        acc_we = 1'b0;
  logic        init_done = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] mem_arr [0:255];

  assign mem_ready  = mem_manual ? man_ready  : mdl_ready;
  assign mem_rvalid = mem_manual ? man_rvalid : mdl_rvalid;
  assign mem_rdata  = mem_manual ? man_rdata  : mdl_rdata;

  always @(negedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) mem_arr[i] = init_word(8'(i));
      mem_arr[4] = 32'h00500293;
      init_done = 1'b1;
    end
    if (!rst) begin
      mdl_ready = 1'b0; mdl_rvalid = 1'b0; wait_cnt = 0;
    end else if (mdl_ready) begin
      mdl_ready  = 1'b0;
      mdl_rvalid = 1'b1;
      mdl_rdata  = acc_we ? 32'hBAD0BAD0 : mem_arr[acc_addr[9:2]];
    end else if (mdl_rvalid) begin
      mdl_rvalid = 1'b0;
    end else if (mem_req && !mem_manual) begin
      if (wait_cnt >= 1) begin
        mdl_ready = 1'b1; wait_cnt = 0;
        acc_addr = mem_addr; acc_we = mem_we;
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) mem_arr[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Response monitor pops the scoreboard on every rvalid
  always @(negedge clk) begin
    if (if_rvalid) begin
      chk("if_rv_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("if_rv_owner", 64'(mon_e.is_d), 64'd0);
        chk("if_rdata", 64'(if_rdata), 64'(mon_e.rdata));
      end
    end
    if (d_rvalid) begin
      chk("d_rv_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("d_rv_owner", 64'(mon_e.is_d), 64'd1);
        chk("d_rdata", 64'(d_rdata), 64'(mon_e.rdata));
      end
    end
  end

  task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr);
    exp_t e;
    e.is_d = is_d;
    if (is_d && we) begin
      e.rdata = last_d;
    end else begin
      e.rdata = mem_arr[addr[9:2]];
      if (is_d) last_d = e.rdata;
    end
    sb.push_back(e);
  endtask

  // Raise a request at a negedge, wait for its grant, then drop it
  task automatic do_req(input bit is_d, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int n;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    push_exp(is_d, we, addr);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? d_gnt : if_gnt) && n < 20);
    chk("gnt_seen", 64'(is_d ? d_gnt : if_gnt), 64'd1);
    if (is_d) d_req = 1'b0; else if_req = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(n < 60), 64'd1);
  endtask

  initial begin
    int n;
    int pulses;
    bit got[$];
    bit exp_owner[8];
    logic [31:0] w;
    exp_owner = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem", 64'({mem_req, mem_we, mem_be, mem_addr} != 38'd0 || mem_wdata != 32'd0), 64'd0);
    chk("rst_resp", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid} != 4'd0 || if_rdata != 32'd0 || d_rdata != 32'd0), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch: grant after one edge, response after four
    do_req(1'b0, 1'b0, 32'h10, 32'h0, 4'h0);
    chk("f_mem_addr", 64'(mem_addr), 64'h10);
    chk("f_mem_we", 64'(mem_we), 64'd0);
    chk("f_mem_be", 64'(mem_be), 64'hf);
    chk("f_busy", 64'(busy), 64'd1);
    n = 1;
    while (!if_rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("f_latency", 64'(n), 64'd4);
    chk("f_rdata_const", 64'(if_rdata), 64'h00500293);
    wait_idle();

    // Load to set d_rdata, then a partial store that must not disturb it
    do_req(1'b1, 1'b0, 32'h200, 32'h0, 4'hf);
    wait_idle();
    do_req(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
    chk("s_mem_we", 64'(mem_we), 64'd1);
    chk("s_mem_addr", 64'(mem_addr), 64'h100);
    chk("s_mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    chk("s_mem_be", 64'(mem_be), 64'h3);
    chk("s_if_gnt", 64'(if_gnt), 64'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (d_rvalid) pulses++;
    end
    chk("s_rvalid_pulses", 64'(pulses), 64'd1);
    chk("s_d_rdata_kept", 64'(d_rdata), 64'(init_word(8'd128)));
    w = init_word(8'd64);
    chk("s_mem_written", 64'(mem_arr[64]), 64'({w[31:16], 16'hBEEF}));
    wait_idle();

    // Both sides requesting continuously: d,d,d,if,d,d,d,if
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hf;
    if_req = 1'b1; if_addr = 32'h80;
    for (int i = 0; i < 8; i++) push_exp(exp_owner[i], 1'b0, exp_owner[i] ? 32'h40 : 32'h80);
    n = 0;
    while (got.size() < 8 && n < 200) begin
      @(negedge clk);
      n++;
      if (d_gnt) got.push_back(1'b1);
      if (if_gnt) got.push_back(1'b0);
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("arb_grants", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      if (i < got.size()) chk("arb_order", 64'(got[i]), 64'(exp_owner[i]));
    wait_idle();

    // mem_ready low for 5 cycles in ISSUE with a spurious rvalid
    mem_manual = 1'b1;
    do_req(1'b0, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_mem_req", 64'(mem_req), 64'd1);
      chk("stall_fields", 64'({mem_we, mem_be, mem_addr}), 64'({1'b0, 4'hf, 32'h20}));
      chk("stall_busy", 64'(busy), 64'd1);
      man_rvalid = (i == 1);
      man_rdata  = (i == 1) ? 32'h0BAD0BAD : 32'h0;
      @(negedge clk);
    end
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    chk("wait_mem_req", 64'(mem_req), 64'd0);
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_no_rv", 64'(if_rvalid), 64'd0);
    man_rvalid = 1'b1;
    man_rdata  = init_word(8'd8);
    @(negedge clk);
    man_rvalid = 1'b0;
    chk("stall_resp", 64'(if_rvalid), 64'd1);
    wait_idle();

    // Reset while in WAIT, then a late rvalid that must be dropped
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'hf;
    @(negedge clk);
    chk("r_d_gnt", 64'(d_gnt), 64'd1);
    d_req = 1'b0;
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    chk("r_in_wait", 64'({busy, mem_req}), 64'h2);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("r_busy_clear", 64'(busy), 64'd0);
    man_rvalid = 1'b1;
    man_rdata  = 32'h00001234;
    @(negedge clk);
    man_rvalid = 1'b0;
    last_d = 32'h0;
    repeat (2) begin
      chk("r_no_rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
      chk("r_outputs_zero", 64'({busy, if_gnt, d_gnt, mem_req, mem_we, mem_be} != 9'd0 ||
                                 mem_addr != 32'd0 || mem_wdata != 32'd0 ||
                                 if_rdata != 32'd0 || d_rdata != 32'd0), 64'd0);
      @(negedge clk);
    end
    mem_manual = 1'b0;

`ifdef RISCV_ARB_STATS_EN
    // Two fetches, three stores; the second fetch waits behind the third store
    do_req(1'b0, 1'b0, 32'h30, 32'h0, 4'h0);
    wait_idle();
    do_req(1'b1, 1'b1, 32'h140, 32'h11111111, 4'hf);
    wait_idle();
    do_req(1'b1, 1'b1, 32'h144, 32'h22222222, 4'hf);
    wait_idle();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h148; d_wdata = 32'h33333333; d_be = 4'hf;
    push_exp(1'b1, 1'b1, 32'h148);
    @(negedge clk);
    chk("st_d_gnt", 64'(d_gnt), 64'd1);
    d_req = 1'b0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h34;
    push_exp(1'b0, 1'b0, 32'h34);
    n = 0;
    while (!if_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("st_if_gnt", 64'(if_gnt), 64'd1);
    if_req = 1'b0;
    wait_idle();
    chk("stat_if_cnt", 64'(stat_if_cnt), 64'd2);
    chk("stat_d_cnt", 64'(stat_d_cnt), 64'd3);
    chk("stat_stall_cnt", 64'(stat_stall_cnt), 64'd4);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
